regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file for the pipelined RISC-V core.
//  Adds NRD read ports, NWR write ports and a per-register pending scoreboard, which
//  gives decode hazard status. A post-reset init sequencer zeroes the array one entry per cycle.
//  Sits between decode (read/issue) and writeback (write) stages.
// PARAMETERS
//  XLEN   32  data width in bits
//  NREGS  32  number of architectural registers (power of 2, >=4)
//  NRD    2   number of read ports
//  NWR    2   number of write ports; a higher port index has higher priority
//  AW     $clog2(NREGS)  address width (derived, not overridden)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, asynchronous, active-high
//  init_done  out  1         array zeroed and block accepting traffic
//  wr_en      in   NWR       per-port write enable
//  wr_addr    in   NWR*AW    write addresses, port i at [i*AW +: AW]
//  wr_data    in   NWR*XLEN  write data, port i at [i*XLEN +: XLEN]
//  rd_en      in   NRD       per-port read enable
//  rd_addr    in   NRD*AW    read addresses
//  rd_data    out  NRD*XLEN  read data (combinational)
//  rd_busy    out  NRD       pending bit of the addressed register (combinational)
//  iss_en     in   1         issue: mark iss_addr pending
//  iss_addr   in   AW        destination register of the issued instruction
//  flush      in   1         clear all pending bits (pipeline flush)
// BEHAVIOUR
//  - Reset (async): FSM=INIT, init_ptr=0, init_done=0, all pending bits=0. Array contents undefined until INIT completes.
//  - FSM INIT: each cycle writes 0 to reg[init_ptr] and increments init_ptr.
//    At init_ptr==NREGS-1 -> RUN. init_done=1 from the next cycle, so it rises NREGS cycles after rst deasserts.
//  - In INIT: wr_en, iss_en and flush are ignored; rd_data=0; rd_busy=0.
//  - RUN is terminal until rst. rst asserted mid-RUN restarts INIT immediately and clears the scoreboard.
//  - Register 0: reads 0, never written, never pending (iss_addr==0 ignored).
//  - Writes (RUN): reg[wr_addr[i]] <= wr_data[i] on the clock edge.
//    Same address on several ports: the highest enabled port index wins.
//  - Scoreboard: a write to addr clears pending[addr]. iss_en sets pending[iss_addr].
//    Issue and write to the same addr in the same cycle: pending ends up 1.
//    flush clears all bits. flush+iss_en in the same cycle: only iss_addr ends up pending.
//  - Read: rd_en=0 or addr 0 -> rd_data=0, rd_busy=0. Otherwise rd_data=reg[addr], rd_busy=pending[addr].
//    No read latency.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when an enabled write targets a read address in the same cycle,
//    rd_data=wr_data of the winning write port and rd_busy=0,
//    unless a same-cycle iss_en targets that addr, in which case rd_busy=1.
//  REGFILE_BYPASS_EN undefined: reads return the pre-edge array value and the pre-edge pending bit.
//    The written value is visible from the next cycle.
// STRUCTURE
//  - Shared package rf_pkg: XLEN/NREGS defaults; ZERO_WORD and ZERO_REG constants;
//    typedef rf_state_e {RF_INIT, RF_RUN}.
//  - One sub-module, rf_scoreboard: pending[NREGS] vector, issue/write-clear/flush logic and busy lookup.
//  - Array, write-priority mux, init sequencer and read/bypass muxes stay in the top module.
// TESTING
//  1. Deassert rst; count cycles -> init_done=1 exactly 32 cycles later. All 32 reads return 0.
//  2. RUN: port0 writes x5=0xDEADBEEF and port1 writes x5=0x12345678 in the same cycle ->
//     next cycle read x5 returns 0x12345678.
//  3. Write x0=0xFFFFFFFF and iss_addr=0 -> read x0 returns 0 with rd_busy=0.
//  4. iss x7, then write x7=0xA5 two cycles later -> rd_busy(x7)=1 for 2 cycles then 0.
//     iss x7 and write x7 in the same cycle -> busy stays 1. flush -> busy 0 on all ports.
//  5. Bypass: write x3=0x55 and read x3 in the same cycle.
//     With REGFILE_BYPASS_EN: rd_data=0x55, busy=0. Without: old value, then 0x55 the next cycle.
//  6. Assert rst mid-RUN with x9 pending -> init_done=0, busy=0, reads return 0.
//     Full re-init takes 32 cycles and ignores writes issued during INIT.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// zero constants and the init/run state type.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;
  localparam int unsigned         ZERO_REG  = 0;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard. Issue sets a bit, a write clears it and
// flush clears everything. Issue wins over a same-cycle write or flush.
// Nothing changes while the register file is still initialising.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic              i_flush,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_busy
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // Next pending vector: flush, then write clears, then issue sets last so it wins.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so later statements override earlier ones and no latch
    // is inferred on paths that skip an assignment.
    w_pending_nxt = r_pending;
    if (i_run) begin
      if (i_flush) begin
        w_pending_nxt = '0;
      end
      for (int i = 0; i < NWR; i++) begin
        if (i_wr_en[i]) begin
          w_pending_nxt[i_wr_addr[i*AW +: AW]] = 1'b0;
        end
      end
      if (i_iss_en && (i_iss_addr != AW'(ZERO_REG))) begin
        w_pending_nxt[i_iss_addr] = 1'b1;
      end
    end
  end

  // Pending register; cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Raw busy lookup per read port; masking is done by the caller.
  for (genvar p = 0; p < NRD; p++) begin : g_busy
    assign o_busy[p] = r_pending[i_rd_addr[p*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with pending scoreboard and a post-reset
// init sequencer that zeroes one entry per cycle. Register 0 is hardwired to 0.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush
);

  rf_state_e         r_state;
  logic [AW-1:0]     r_init_ptr;
  logic [XLEN-1:0]   r_mem [NREGS];
  logic              w_run;
  logic [NRD-1:0]    w_sb_busy;

  assign w_run     = (r_state == RF_RUN);
  assign init_done = w_run;

  // Init sequencer: walk the pointer over every entry, then stay in RUN until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RF_INIT;
      r_init_ptr <= '0;
    end else if (r_state == RF_INIT) begin
      r_init_ptr <= r_init_ptr + 1'b1;
      if (r_init_ptr == AW'(NREGS - 1)) begin
        r_state <= RF_RUN;
      end
    end
  end

  // Array update: zero fill during INIT, prioritised port writes during RUN.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the init sequencer zeroes it instead,
    // which keeps it mappable onto plain RAM/flop arrays without reset fan-out.
    if (!w_run) begin
      r_mem[r_init_ptr] <= XLEN'(ZERO_WORD);
    end else begin
      // Ascending loop: the last matching assignment (highest port) wins.
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != AW'(ZERO_REG))) begin
          r_mem[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_iss_en   (iss_en),
    .i_iss_addr (iss_addr),
    .i_flush    (flush),
    .i_rd_addr  (rd_addr),
    .o_busy     (w_sb_busy)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rd_addr[p*AW +: AW];

    // Read mux: zero when idle, initialising or addressing x0; optional bypass.
    always_comb begin
      w_data = XLEN'(ZERO_WORD);
      w_busy = 1'b0;
      if (w_run && rd_en[p] && (w_addr != AW'(ZERO_REG))) begin
        w_data = r_mem[w_addr];
        w_busy = w_sb_busy[p];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i*AW +: AW] == w_addr)) begin
            w_data = wr_data[i*XLEN +: XLEN];
            w_busy = iss_en && (iss_addr == w_addr);
          end
        end
`endif
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_data;
    assign rd_busy[p]              = w_busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: behavioural model compared every
// negative edge, plus directed literal expectations for the key scenarios.
module tb_regfile_mp_sb;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           init_done;
  logic [1:0]     wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XL-1:0] wr_data;
  logic [1:0]     rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*XL-1:0] rd_data;
  logic [1:0]     rd_busy;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic           flush;

  int n_checks = 0;
  int n_errs   = 0;

  regfile_mp_sb dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [XL-1:0] m_mem  [NR];
  bit            m_pend [NR];
  int            m_cnt = 0;   // clock edges seen since reset released

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0;
      foreach (m_pend[r]) m_pend[r] = 1'b0;
    end else if (m_cnt < NR) begin
      m_cnt++;
      if (m_cnt == NR) foreach (m_mem[r]) m_mem[r] = '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (wr_en[i] && wr_addr[i*AW +: AW] != 0) m_mem[wr_addr[i*AW +: AW]] = wr_data[i*XL +: XL];
      if (flush) foreach (m_pend[r]) m_pend[r] = 1'b0;
      for (int i = 0; i < 2; i++)
        if (wr_en[i]) m_pend[wr_addr[i*AW +: AW]] = 1'b0;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic model_compare();
    bit run;
    run = !rst && (m_cnt >= NR);
    check("init_done", {63'd0, init_done}, {63'd0, run});
    for (int p = 0; p < 2; p++) begin
      logic [AW-1:0] a;
      logic [XL-1:0] ed;
      bit            eb;
      a  = rd_addr[p*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (run && rd_en[p] && a != 0) begin
        ed = m_mem[a];
        eb = m_pend[a];
        if (BYP) begin
          for (int i = 0; i < 2; i++)
            if (wr_en[i] && wr_addr[i*AW +: AW] == a) begin
              ed = wr_data[i*XL +: XL];
              eb = iss_en && (iss_addr == a);
            end
        end
      end
      check($sformatf("model_rd_data%0d", p), {32'd0, rd_data[p*XL +: XL]}, {32'd0, ed});
      check($sformatf("model_rd_busy%0d", p), {63'd0, rd_busy[p]}, {63'd0, eb});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    model_compare();
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input int a, input logic [XL-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a[AW-1:0];
    wr_data[p*XL +: XL] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_drive();
    wr_en = 2'($urandom);
    rd_en = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
    for (int i = 0; i < 2; i++) begin
      wr_addr[i*AW +: AW] = rand_addr();
      wr_data[i*XL +: XL] = $urandom;
      rd_addr[i*AW +: AW] = rand_addr();
    end
    iss_en   = ($urandom_range(0, 3) == 0);
    iss_addr = rand_addr();
    flush    = ($urandom_range(0, 15) == 0);
  endtask

  task automatic expect_rd(input string nm, input int p, input logic [XL-1:0] d, input bit b);
    check({nm, "_data"}, {32'd0, rd_data[p*XL +: XL]}, {32'd0, d});
    check({nm, "_busy"}, {63'd0, rd_busy[p]}, {63'd0, b});
  endtask

  // Counts edges from reset release to init_done while junk traffic is driven.
  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      step();
      n++;
      if (!init_done) rand_drive();
    end
    idle();
    check(nm, 64'(n), 64'(NR));
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < NR; a++) begin
      idle();
      set_rd(0, a);
      set_rd(1, NR - 1 - a);
      @(negedge clk);
      expect_rd({nm, "0"}, 0, '0, 1'b0);
      expect_rd({nm, "1"}, 1, '0, 1'b0);
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Init sequence and zeroed array
    wait_init("init_cycles");
    read_all_zero("zero");

    // Same-address write on both ports: port 1 wins
    idle(); set_wr(0, 5, 32'hDEADBEEF); set_wr(1, 5, 32'h12345678); step();
    idle(); set_rd(0, 5); @(negedge clk);
    expect_rd("wr_prio", 0, 32'h12345678, 1'b0); step();

    // x0 is never written and never pending
    idle(); set_wr(0, 0, 32'hFFFFFFFF); iss_en = 1'b1; iss_addr = '0; set_rd(1, 0);
    @(negedge clk); expect_rd("x0_same", 1, '0, 1'b0); step();
    idle(); set_rd(0, 0); set_rd(1, 0); @(negedge clk);
    expect_rd("x0_after0", 0, '0, 1'b0); expect_rd("x0_after1", 1, '0, 1'b0); step();

    // Issue x7, write it two cycles later
    idle(); iss_en = 1'b1; iss_addr = 5'd7; set_rd(0, 7);
    @(negedge clk); expect_rd("iss_c0", 0, '0, 1'b0); step();
    idle(); set_rd(0, 7); @(negedge clk); expect_rd("iss_c1", 0, '0, 1'b1); step();
    idle(); set_wr(1, 7, 32'hA5); set_rd(0, 7); @(negedge clk);
    expect_rd("iss_c2", 0, BYP ? 32'hA5 : 32'h0, !BYP); step();
    idle(); set_rd(0, 7); set_rd(1, 7); @(negedge clk);
    expect_rd("iss_c3p0", 0, 32'hA5, 1'b0); expect_rd("iss_c3p1", 1, 32'hA5, 1'b0); step();

    // Issue and write x7 in the same cycle: stays pending
    idle(); iss_en = 1'b1; iss_addr = 5'd7; set_wr(0, 7, 32'h77); set_rd(0, 7); @(negedge clk);
    expect_rd("isswr_same", 0, BYP ? 32'h77 : 32'hA5, BYP); step();
    idle(); set_rd(0, 7); set_rd(1, 7); @(negedge clk);
    expect_rd("isswr_p0", 0, 32'h77, 1'b1); expect_rd("isswr_p1", 1, 32'h77, 1'b1); step();

    // Flush with a same-cycle issue of x10, then a plain flush
    idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd10; step();
    idle(); set_rd(0, 7); set_rd(1, 10); @(negedge clk);
    expect_rd("flush_iss7", 0, 32'h77, 1'b0); expect_rd("flush_iss10", 1, '0, 1'b1); step();
    idle(); flush = 1'b1; step();
    idle(); set_rd(0, 10); set_rd(1, 7); @(negedge clk);
    expect_rd("flush_p0", 0, '0, 1'b0); expect_rd("flush_p1", 1, 32'h77, 1'b0); step();

    // Same-cycle write and read of x3
    idle(); set_wr(0, 3, 32'h55); set_rd(0, 3); @(negedge clk);
    expect_rd("byp_same", 0, BYP ? 32'h55 : 32'h0, 1'b0); step();
    idle(); set_rd(0, 3); @(negedge clk); expect_rd("byp_next", 0, 32'h55, 1'b0); step();

    // Randomised traffic, checked by the model every cycle
    repeat (3000) begin
      rand_drive();
      step();
    end

    // Reset mid-RUN with x9 pending
    idle(); iss_en = 1'b1; iss_addr = 5'd9; step();
    idle(); set_rd(0, 9); @(negedge clk);
    check("x9_pending", {63'd0, rd_busy[0]}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("rst_init_done", {63'd0, init_done}, 64'd0);
    expect_rd("rst_rd", 0, '0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init("reinit_cycles");
    read_all_zero("rezero");

    idle();
    step();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

endmodule
